// File: rtl/nvme_doorbell_sched.sv
// NVMe SQ-tail / CQ-head doorbell scheduler sharing one AXI-Lite write master.
// Define NVME_DB_BRESP_CHK_EN to flag error responses and retry the doorbell.
module nvme_doorbell_sched #(
    parameter int          DEPTH      = 16,
    parameter int          QID        = 1,
    parameter int          DSTRD      = 0,
    parameter logic [31:0] DB_BASE    = 32'h1000,
    parameter int          ADDR_WIDTH = 32,
    localparam int         QW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sqt_valid,
    input  logic [QW-1:0]         sqt_tail,
    output logic                  sqt_ready,
    input  logic                  cqe_valid,
    input  logic [15:0]           cqe_sqhead,
    input  logic [15:0]           cqe_cid,
    input  logic                  cqe_phase,
    input  logic [14:0]           cqe_status,
    output logic                  cqe_ready,
    output logic                  cmp_valid,
    input  logic                  cmp_ready,
    output logic [15:0]           cmp_cid,
    output logic [14:0]           cmp_status,
    output logic [QW-1:0]         sq_head,
    output logic [ADDR_WIDTH-1:0] db_awaddr,
    output logic                  db_awvalid,
    input  logic                  db_awready,
    output logic [31:0]           db_wdata,
    output logic [3:0]            db_wstrb,
    output logic                  db_wvalid,
    input  logic                  db_wready,
    input  logic [1:0]            db_bresp,
    input  logic                  db_bvalid,
    output logic                  db_bready,
    output logic                  phase_err,
    output logic                  db_err
);
    localparam int STRIDE = 4 << DSTRD;
    localparam logic [ADDR_WIDTH-1:0] SQ_DB =
        ADDR_WIDTH'(DB_BASE + 32'(2 * QID * STRIDE));
    localparam logic [ADDR_WIDTH-1:0] CQ_DB =
        ADDR_WIDTH'(DB_BASE + 32'((2 * QID + 1) * STRIDE));

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

    state_t                r_state;
    logic [QW-1:0]         r_sq_tail;
    logic [QW-1:0]         r_cq_head;
    logic [QW-1:0]         r_sq_head;
    logic                  r_sq_pend;
    logic                  r_cq_pend;
    logic                  r_exp_phase;
    logic                  r_last_gnt;
    logic                  r_cmp_valid;
    logic [15:0]           r_cmp_cid;
    logic [14:0]           r_cmp_status;
    logic                  r_phase_err;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [QW-1:0]         r_wr_val;
    logic [3:0]            r_wstrb;

    logic w_cqe_acc;
    logic w_cqe_hit;
    logic w_idle;
    logic w_pick_sq;
    logic w_gnt_sq;
    logic w_gnt_cq;
    logic w_retry_sq;
    logic w_retry_cq;
    logic w_unused_sqh;

    assign sqt_ready  = 1'b1;
    assign cqe_ready  = ~r_cmp_valid | cmp_ready;
    assign w_cqe_acc  = cqe_valid & cqe_ready;
    assign w_cqe_hit  = w_cqe_acc & (cqe_phase == r_exp_phase);
    assign w_idle     = (r_state == S_IDLE);
    // r_last_gnt: 0 = SQ, 1 = CQ; on a tie the side not served last wins
    assign w_pick_sq  = r_sq_pend & (~r_cq_pend | r_last_gnt);
    assign w_gnt_sq   = w_idle & w_pick_sq;
    assign w_gnt_cq   = w_idle & r_cq_pend & ~w_pick_sq;
    assign w_unused_sqh = ^cqe_sqhead[15:QW];

`ifdef NVME_DB_BRESP_CHK_EN
    logic w_berr;
    logic r_db_err;
    assign w_berr     = (r_state == S_RESP) & db_bvalid & (db_bresp != 2'b00);
    assign w_retry_sq = w_berr & ~r_last_gnt;
    assign w_retry_cq = w_berr & r_last_gnt;
    assign db_err     = r_db_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_db_err <= 1'b0;
        else if (w_berr) r_db_err <= 1'b1;
    end
`else
    logic w_unused_bresp;
    assign w_unused_bresp = ^db_bresp;
    assign w_retry_sq     = 1'b0;
    assign w_retry_cq     = 1'b0;
    assign db_err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sq_tail <= '0;
            r_sq_pend <= 1'b0;
        end else begin
            if (sqt_valid) r_sq_tail <= sqt_tail;
            if (sqt_valid | w_retry_sq) r_sq_pend <= 1'b1;
            else if (w_gnt_sq) r_sq_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cq_head    <= '0;
            r_exp_phase  <= 1'b1;
            r_cq_pend    <= 1'b0;
            r_sq_head    <= '0;
            r_cmp_valid  <= 1'b0;
            r_cmp_cid    <= '0;
            r_cmp_status <= '0;
            r_phase_err  <= 1'b0;
        end else begin
            if (w_cqe_hit) begin
                r_cmp_valid  <= 1'b1;
                r_cmp_cid    <= cqe_cid;
                r_cmp_status <= cqe_status;
                r_sq_head    <= cqe_sqhead[QW-1:0];
                r_cq_head    <= r_cq_head + 1'b1;
                if (r_cq_head == QW'(DEPTH - 1)) r_exp_phase <= ~r_exp_phase;
            end else if (cmp_ready) begin
                r_cmp_valid <= 1'b0;
            end
            if (w_cqe_acc & ~w_cqe_hit) r_phase_err <= 1'b1;
            if (w_cqe_hit | w_retry_cq) r_cq_pend <= 1'b1;
            else if (w_gnt_cq) r_cq_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_last_gnt <= 1'b1;
            r_awaddr   <= '0;
            r_wr_val   <= '0;
            r_wstrb    <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt_sq | w_gnt_cq) begin
                        r_awaddr   <= w_gnt_sq ? SQ_DB : CQ_DB;
                        r_wr_val   <= w_gnt_sq ? r_sq_tail : r_cq_head;
                        r_last_gnt <= w_gnt_cq;
                        r_wstrb    <= 4'hF;
                        r_awvalid  <= 1'b1;
                        r_wvalid   <= 1'b1;
                        r_state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (db_awready) r_awvalid <= 1'b0;
                    if (db_wready) r_wvalid <= 1'b0;
                    if ((~r_awvalid | db_awready) & (~r_wvalid | db_wready)) begin
                        r_bready <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (db_bvalid) begin
                        r_bready <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmp_valid  = r_cmp_valid;
    assign cmp_cid    = r_cmp_cid;
    assign cmp_status = r_cmp_status;
    assign sq_head    = r_sq_head;
    assign phase_err  = r_phase_err;
    assign db_awaddr  = r_awaddr;
    assign db_awvalid = r_awvalid;
    assign db_wdata   = {{(32 - QW){1'b0}}, r_wr_val};
    assign db_wstrb   = r_wstrb;
    assign db_wvalid  = r_wvalid;
    assign db_bready  = r_bready;
endmodule

// File: tb/tb_nvme_doorbell_sched.sv
// Self-checking bench for nvme_doorbell_sched: directed steps plus a
// randomized CQE/SQ-tail stream checked against a queue-based model.
module tb_nvme_doorbell_sched;
    localparam int DEPTH = 16;
    localparam int QW = 4;
    localparam logic [31:0] SQA = 32'h1008;
    localparam logic [31:0] CQA = 32'h100C;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          sqt_valid = 1'b0;
    logic [QW-1:0] sqt_tail = '0;
    logic          sqt_ready;
    logic          cqe_valid = 1'b0;
    logic [15:0]   cqe_sqhead = '0;
    logic [15:0]   cqe_cid = '0;
    logic          cqe_phase = 1'b0;
    logic [14:0]   cqe_status = '0;
    logic          cqe_ready;
    logic          cmp_valid;
    logic          cmp_ready = 1'b1;
    logic [15:0]   cmp_cid;
    logic [14:0]   cmp_status;
    logic [QW-1:0] sq_head;
    logic [31:0]   db_awaddr;
    logic          db_awvalid;
    logic          db_awready = 1'b1;
    logic [31:0]   db_wdata;
    logic [3:0]    db_wstrb;
    logic          db_wvalid;
    logic          db_wready = 1'b1;
    logic [1:0]    db_bresp = 2'b00;
    logic          db_bvalid = 1'b0;
    logic          db_bready;
    logic          phase_err;
    logic          db_err;

    nvme_doorbell_sched dut (
        .clk(clk), .rstn(rstn),
        .sqt_valid(sqt_valid), .sqt_tail(sqt_tail), .sqt_ready(sqt_ready),
        .cqe_valid(cqe_valid), .cqe_sqhead(cqe_sqhead), .cqe_cid(cqe_cid),
        .cqe_phase(cqe_phase), .cqe_status(cqe_status), .cqe_ready(cqe_ready),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
        .cmp_cid(cmp_cid), .cmp_status(cmp_status), .sq_head(sq_head),
        .db_awaddr(db_awaddr), .db_awvalid(db_awvalid), .db_awready(db_awready),
        .db_wdata(db_wdata), .db_wstrb(db_wstrb), .db_wvalid(db_wvalid),
        .db_wready(db_wready), .db_bresp(db_bresp), .db_bvalid(db_bvalid),
        .db_bready(db_bready), .phase_err(phase_err), .db_err(db_err)
    );

    int total = 0;
    int bad = 0;
    logic aw_stall = 1'b0;
    logic [1:0] bresp_cfg = 2'b00;
    logic [31:0] lg_addr[$];
    logic [31:0] lg_data[$];
    logic [30:0] got_cmp[$];
    logic [30:0] exp_cmp[$];
    logic [31:0] lat_addr = '0;
    logic [31:0] lat_data = '0;

    int m_head = 0;
    bit m_phase = 1'b1;
    logic [3:0] m_sqh = '0;
    bit m_perr = 1'b0;

    // zero-wait AXI-Lite slave; AW can be stalled, B follows bready
    initial forever begin
        @(posedge clk);
        #1;
        db_awready = ~aw_stall;
        db_wready = 1'b1;
        db_bvalid = db_bready;
        db_bresp = bresp_cfg;
    end

    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (db_awvalid && db_awready) lat_addr = db_awaddr;
            if (db_wvalid && db_wready) lat_data = db_wdata;
            if (db_bvalid && db_bready) begin
                lg_addr.push_back(lat_addr);
                lg_data.push_back(lat_data);
            end
            if (cmp_valid && cmp_ready) got_cmp.push_back({cmp_cid, cmp_status});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic model_cqe(input logic [15:0] cid, input logic [14:0] st,
                             input logic [15:0] sqh, input logic ph);
        if (ph == m_phase) begin
            exp_cmp.push_back({cid, st});
            m_sqh = sqh[3:0];
            m_head = (m_head + 1) % DEPTH;
            if (m_head == 0) m_phase = ~m_phase;
        end else begin
            m_perr = 1'b1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        sqt_valid = 1'b0;
        cqe_valid = 1'b0;
        cmp_ready = 1'b1;
        aw_stall = 1'b0;
        bresp_cfg = 2'b00;
        #1;
        chk("rst_awvalid", db_awvalid, 0);
        chk("rst_wvalid", db_wvalid, 0);
        chk("rst_bready", db_bready, 0);
        chk("rst_cmp_valid", cmp_valid, 0);
        tick();
        tick();
        chk("rst_sqt_ready", sqt_ready, 1);
        chk("rst_cqe_ready", cqe_ready, 1);
        chk("rst_awaddr", db_awaddr, 0);
        chk("rst_wdata", db_wdata, 0);
        chk("rst_wstrb", db_wstrb, 0);
        chk("rst_sq_head", sq_head, 0);
        chk("rst_phase_err", phase_err, 0);
        chk("rst_db_err", db_err, 0);
        chk("rst_cmp_cid", cmp_cid, 0);
        rstn = 1'b1;
        lg_addr.delete();
        lg_data.delete();
        got_cmp.delete();
        exp_cmp.delete();
        m_head = 0;
        m_phase = 1'b1;
        m_sqh = '0;
        m_perr = 1'b0;
        tick();
    endtask

    task automatic cqe_send(input logic ph);
        logic [15:0] cid;
        logic [15:0] sqh;
        logic [14:0] st;
        int n;
        cid = 16'($urandom);
        sqh = 16'($urandom);
        st = 15'($urandom);
        cqe_valid = 1'b1;
        cqe_cid = cid;
        cqe_sqhead = sqh;
        cqe_status = st;
        cqe_phase = ph;
        #1;
        n = 0;
        while (!cqe_ready && n < 100) begin
            tick();
            n++;
        end
        chk("cqe_wait", 32'(n < 100), 1);
        tick();
        cqe_valid = 1'b0;
        model_cqe(cid, st, sqh, ph);
    endtask

    task automatic wait_wr(input string tag, input int n);
        int k;
        k = 0;
        while (lg_addr.size() < n && k < 200) begin
            tick();
            k++;
        end
        chk(tag, 32'(lg_addr.size() >= n), 1);
    endtask

    task automatic chk_wr(input string tag, input int i,
                          input logic [31:0] a, input logic [31:0] d);
        if (i < lg_addr.size()) begin
            chk({tag, "_addr"}, lg_addr[i], a);
            chk({tag, "_data"}, lg_data[i], d);
        end else begin
            chk({tag, "_present"}, 32'(lg_addr.size()), 32'(i + 1));
        end
    endtask

    function automatic logic [31:0] last_wr(input logic [31:0] a);
        for (int i = lg_addr.size() - 1; i >= 0; i--)
            if (lg_addr[i] == a) return lg_data[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_cmps(input string tag);
        chk({tag, "_count"}, 32'(got_cmp.size()), 32'(exp_cmp.size()));
        for (int i = 0; i < got_cmp.size() && i < exp_cmp.size(); i++)
            chk({tag, "_payload"}, 32'(got_cmp[i]), 32'(exp_cmp[i]));
    endtask

    task automatic tie(input logic [3:0] t);
        logic [15:0] cid;
        logic [15:0] sqh;
        logic [14:0] st;
        cid = 16'($urandom);
        sqh = 16'($urandom);
        st = 15'($urandom);
        sqt_valid = 1'b1;
        sqt_tail = t;
        cqe_valid = 1'b1;
        cqe_cid = cid;
        cqe_sqhead = sqh;
        cqe_status = st;
        cqe_phase = m_phase;
        #1;
        chk("tie_cqe_ready", cqe_ready, 1);
        tick();
        sqt_valid = 1'b0;
        cqe_valid = 1'b0;
        model_cqe(cid, st, sqh, m_phase);
    endtask

    initial begin
        logic [15:0] b_cid;
        logic [15:0] b_sqh;
        logic [14:0] b_st;
        logic [3:0] m_tail;
        bit acc;
        bit tail_sent;
        int base;

        // reset aborts an in-flight doorbell
        do_reset();
        aw_stall = 1'b1;
        tick();
        sqt_valid = 1'b1;
        sqt_tail = 4'd9;
        tick();
        sqt_valid = 1'b0;
        tick();
        chk("abort_awvalid_up", db_awvalid, 1);
        do_reset();
        settle(10);
        chk("abort_no_write", 32'(lg_addr.size()), 0);
        chk("abort_awvalid", db_awvalid, 0);

        // single SQ tail
        sqt_valid = 1'b1;
        sqt_tail = 4'd3;
        tick();
        sqt_valid = 1'b0;
        chk("single_aw_early", db_awvalid, 0);
        tick();
        chk("single_awvalid", db_awvalid, 1);
        chk("single_wvalid", db_wvalid, 1);
        chk("single_awaddr", db_awaddr, SQA);
        chk("single_wdata", db_wdata, 3);
        chk("single_wstrb", db_wstrb, 4'hF);
        wait_wr("single_done", 1);
        chk_wr("single", 0, SQA, 3);

        // coalescing under AW stall
        settle(3);
        base = lg_addr.size();
        aw_stall = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            sqt_valid = 1'b1;
            sqt_tail = 4'(i);
            tick();
        end
        sqt_valid = 1'b0;
        settle(10);
        chk("coal_hold_aw", db_awvalid, 1);
        chk("coal_hold_addr", db_awaddr, SQA);
        chk("coal_hold_data", db_wdata, 1);
        aw_stall = 1'b0;
        wait_wr("coal_done", base + 2);
        settle(10);
        chk("coal_count", 32'(lg_addr.size()), 32'(base + 2));
        chk_wr("coal_first", base, SQA, 1);
        chk_wr("coal_second", base + 1, SQA, 3);

        // round robin
        do_reset();
        tie(4'd5);
        wait_wr("rr1_done", 2);
        settle(5);
        chk_wr("rr1_a", 0, SQA, 5);
        chk_wr("rr1_b", 1, CQA, 1);
        tie(4'd6);
        wait_wr("rr2_done", 4);
        settle(5);
        chk_wr("rr2_a", 2, SQA, 6);
        chk_wr("rr2_b", 3, CQA, 2);
        sqt_valid = 1'b1;
        sqt_tail = 4'd7;
        tick();
        sqt_valid = 1'b0;
        wait_wr("rr_sq_done", 5);
        settle(5);
        chk_wr("rr_sq", 4, SQA, 7);
        tie(4'd8);
        wait_wr("rr3_done", 7);
        settle(5);
        chk_wr("rr3_a", 5, CQA, 3);
        chk_wr("rr3_b", 6, SQA, 8);
        check_cmps("rr_cmp");

        // CQ wrap and phase error
        do_reset();
        for (int i = 0; i < DEPTH; i++) cqe_send(1'b1);
        cqe_send(1'b1);
        chk("wrap_phase_err", phase_err, 32'(m_perr));
        settle(20);
        chk("wrap_cq_head", last_wr(CQA), 32'(m_head));
        check_cmps("wrap_cmp");
        cqe_send(1'b0);
        settle(20);
        chk("wrap_next_head", last_wr(CQA), 32'(m_head));
        chk("wrap_sq_head", sq_head, 32'(m_sqh));
        check_cmps("wrap_cmp2");

        // completion backpressure
        do_reset();
        cmp_ready = 1'b0;
        cqe_send(1'b1);
        chk("bp_cmp_valid", cmp_valid, 1);
        chk("bp_cmp_cid", cmp_cid, 32'(exp_cmp[0][30:15]));
        b_cid = 16'($urandom);
        b_sqh = 16'($urandom);
        b_st = 15'($urandom);
        cqe_valid = 1'b1;
        cqe_cid = b_cid;
        cqe_sqhead = b_sqh;
        cqe_status = b_st;
        cqe_phase = 1'b1;
        #1;
        chk("bp_cqe_ready_low", cqe_ready, 0);
        settle(2);
        chk("bp_cmp_held", cmp_cid, 32'(exp_cmp[0][30:15]));
        chk("bp_none_out", 32'(got_cmp.size()), 0);
        cmp_ready = 1'b1;
        #1;
        chk("bp_cqe_ready_up", cqe_ready, 1);
        tick();
        cqe_valid = 1'b0;
        model_cqe(b_cid, b_st, b_sqh, 1'b1);
        settle(3);
        check_cmps("bp_cmp");
        chk("bp_sq_head", sq_head, 32'(m_sqh));

        // randomized mix against the model
        do_reset();
        m_tail = '0;
        tail_sent = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!cqe_valid && $urandom_range(0, 2) == 0) begin
                cqe_cid = 16'($urandom);
                cqe_sqhead = 16'($urandom);
                cqe_status = 15'($urandom);
                cqe_phase = ($urandom_range(0, 7) == 0) ? ~m_phase : m_phase;
                cqe_valid = 1'b1;
            end
            sqt_valid = ($urandom_range(0, 3) == 0);
            sqt_tail = 4'($urandom);
            cmp_ready = ($urandom_range(0, 3) != 0);
            aw_stall = ($urandom_range(0, 3) == 0);
            #1;
            acc = cqe_valid && cqe_ready;
            if (sqt_valid) begin
                m_tail = sqt_tail;
                tail_sent = 1'b1;
            end
            tick();
            if (acc) begin
                model_cqe(cqe_cid, cqe_status, cqe_sqhead, cqe_phase);
                cqe_valid = 1'b0;
            end
        end
        sqt_valid = 1'b0;
        cmp_ready = 1'b1;
        aw_stall = 1'b0;
        settle(40);
        if (tail_sent) chk("rnd_sq_tail", last_wr(SQA), 32'(m_tail));
        chk("rnd_cq_head", last_wr(CQA), 32'(m_head));
        chk("rnd_sq_head", sq_head, 32'(m_sqh));
        chk("rnd_phase_err", phase_err, 32'(m_perr));
        chk("rnd_idle", db_awvalid | db_wvalid | db_bready, 0);
        check_cmps("rnd_cmp");

`ifdef NVME_DB_BRESP_CHK_EN
        // error response retries the CQ doorbell
        do_reset();
        for (int i = 0; i < 4; i++) cqe_send(1'b1);
        settle(20);
        base = lg_addr.size();
        bresp_cfg = 2'b10;
        cqe_send(1'b1);
        for (int k = 0; k < 50 && !db_err; k++) tick();
        bresp_cfg = 2'b00;
        chk("berr_db_err", db_err, 1);
        settle(20);
        chk("berr_count", 32'(lg_addr.size()), 32'(base + 2));
        chk_wr("berr_fail", base, CQA, 5);
        chk_wr("berr_retry", base + 1, CQA, 5);
        chk("berr_sticky", db_err, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nvme_doorbell_sched.md
# nvme_doorbell_sched

Doorbell scheduler for the NVMe host-side data path. It accepts submission-queue tail updates from the command-issue logic and completion-queue entries from the CQ write sink. It tracks CQ head/phase and returns SQ head and completions to the issuer. A single AXI-Lite master port to the controller BAR is shared between SQ-tail and CQ-head doorbell writes: writes are coalesced and round-robin arbitrated, with one write in flight at a time.

## Interface
Parameters:
- DEPTH, 16: entries per SQ and per CQ (power of 2, ≥2); QW = $clog2(DEPTH)
- QID, 1: I/O queue pair id
- DSTRD, 0: doorbell stride exponent (CAP.DSTRD)
- DB_BASE, 32'h1000: doorbell region offset in BAR
- ADDR_WIDTH, 32: AXI-Lite address width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- sqt_valid  in  1  new SQ tail available
- sqt_tail  in  QW  new SQ tail value
- sqt_ready  out  1  tail accepted
- cqe_valid  in  1  CQ entry written by device
- cqe_sqhead  in  16  CQE DW2[15:0]
- cqe_cid  in  16  CQE DW3[15:0]
- cqe_phase  in  1  CQE DW3[16]
- cqe_status  in  15  CQE DW3[31:17]
- cqe_ready  out  1  entry consumed
- cmp_valid / cmp_ready  out / in  1  completion to issuer
- cmp_cid  out  16,  cmp_status  out  15  completion payload
- sq_head  out  QW  last SQ head reported by controller
- db_awaddr  out  ADDR_WIDTH,  db_awvalid  out 1,  db_awready  in 1  AXI-Lite AW
- db_wdata  out 32,  db_wstrb  out 4,  db_wvalid  out 1,  db_wready  in 1  AXI-Lite W
- db_bresp  in 2,  db_bvalid  in 1,  db_bready  out 1  AXI-Lite B
- phase_err  out  1  sticky: CQE arrived with wrong phase
- db_err  out  1  sticky bresp error (see Configuration)

## Operation
- SQ doorbell address = DB_BASE + (2·QID)·(4<<DSTRD); CQ doorbell address = DB_BASE + (2·QID+1)·(4<<DSTRD). Defaults: 0x1008, 0x100C.
- db_wdata = value zero-extended to 32 bits; db_wstrb = 4'hF.
- SQ path:
  - sqt_ready = 1 always.
  - On accept, sq_tail_reg <= sqt_tail and sq_pend <= 1.
  - A later tail overwrites the earlier one; only the newest value is written (coalescing).
- CQ path, with cq_head (QW bits) and exp_phase (1 bit):
  - cqe accepted when cqe_valid & cqe_ready; cqe_ready = ~cmp_valid | cmp_ready (one-entry output register).
  - cqe_phase == exp_phase:
    - load cmp_cid/cmp_status and set cmp_valid;
    - sq_head <= cqe_sqhead[QW-1:0];
    - cq_head <= cq_head+1; at DEPTH-1 → 0, exp_phase toggles;
    - cq_pend <= 1.
  - Phase mismatch: entry dropped, cq_head unchanged, phase_err set; cmp_valid not asserted.
- Arbiter FSM with states IDLE, ADDR, RESP:
  - IDLE: if exactly one pend is set, grant it. If both are set, grant the one not named by last_gnt.
    - On grant: capture the value into wr_val and wr_addr, clear that pend, set last_gnt, go to ADDR.
  - ADDR: db_awvalid and db_wvalid asserted. Each drops independently after its own handshake. When both are done, go to RESP.
  - RESP: db_bready = 1. On db_bvalid, return to IDLE.
- An update and a capture on the same edge leave pend = 1: set wins over clear, and the new value is written on the next grant.
- Reset values:
  - all outputs 0 except sqt_ready = 1 and cqe_ready = 1;
  - cq_head = 0, exp_phase = 1, sq_tail_reg = 0, last_gnt = CQ (SQ wins the first tie), FSM = IDLE.
- Reset asserted mid-transaction aborts it; the pend flags and any uncommitted doorbell are lost.

## Timing
- sqt accepted at edge N → db_awvalid/db_wvalid high after edge N+1, provided the FSM is IDLE at N+1.
- cqe accepted at edge N → cmp_valid high after edge N. The CQ doorbell is ready to grant at edge N+1.
- With cmp_ready held high, throughput is 1 CQE/cycle. A doorbell write takes at least 3 cycles (IDLE → ADDR → RESP → IDLE) with zero-wait slave.
- db_awvalid/db_wvalid stay asserted until their ready arrives; address and data are stable while valid.
- Minimum gap between back-to-back doorbell writes: 1 IDLE cycle.

## Configuration
- NVME_DB_BRESP_CHK_EN defined:
  - any db_bresp ≠ 2'b00 in RESP sets sticky db_err;
  - the failed write's pend is re-set, so it retries with the newest value.
- Undefined: db_bresp is ignored and db_err is tied 0.

## Test plan
- Single SQ tail: sqt_tail=3, zero-wait slave → one write, awaddr 0x1008, wdata 3, awvalid after edge N+1.
- Coalescing: tails 1, 2, 3 on consecutive cycles while db_awready is held low 10 cycles → exactly two SQ writes, wdata 1 then 3.
- Round robin: SQ and CQ pend set on the same cycle from reset → SQ (0x1008) first, then CQ (0x100C). Repeat the tie → order alternates.
- CQ wrap: 16 CQEs phase=1 then 1 CQE phase=1 → last entry dropped, phase_err=1, cq_head=0. A following CQE with phase=0 is accepted.
- Backpressure: cmp_ready=0 with 2 valid CQEs → first held on cmp, cqe_ready=0. Release → both delivered in order, sq_head equals the second entry's DW2.
- NVME_DB_BRESP_CHK_EN: bresp=2'b10 on a CQ write with head 5 → db_err=1, CQ write retried with wdata 5.
